// File: rtl/accum_sequencer_pkg.sv
// Shared state encoding and datapath width for the accumulator sequencer.
package accum_sequencer_pkg;
  localparam int DATA_W = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/accum_sequencer.sv
// Streaming accumulator around an external 7-bit adder: sums len operands, returns total over valid/ready.
// Optional macro SATURATE_EN: clamp the accumulator to 127 on wrap instead of modulo-128.
module accum_sequencer #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = accum_sequencer_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   adder_in,
  input  logic [DATA_W-1:0]     adder_sum,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_ovf,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);
  import accum_sequencer_pkg::*;

  state_t             state, state_n;
  logic [DATA_W-1:0]  acc, acc_n;
  logic [LEN_W-1:0]   cnt, cnt_n, len_q, len_n, cnt_inc;
  logic               ovf, ovf_n, wrap;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      len_q <= len_n;
      ovf   <= ovf_n;
    end
  end

  // A lost carry always leaves the truncated sum below the old accumulator.
  assign wrap    = (adder_sum < acc);
  assign cnt_inc = cnt + LEN_W'(1);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    len_n     = len_q;
    ovf_n     = ovf;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_n   = len;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          state_n = (len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef SATURATE_EN
          acc_n = wrap ? '1 : adder_sum;
`else
          acc_n = adder_sum;
`endif
          cnt_n = cnt_inc;
          ovf_n = ovf | wrap;
          if (cnt_inc == len_q) state_n = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign adder_in = {in_data, acc};
  assign res_data = acc;
  assign res_ovf  = ovf;
  assign busy     = (state == S_ACCUM) || (state == S_DONE);
endmodule
